// File: rtl/constants_pkg.sv
// Shared definitions for the pipeline control slice: sequencer states,
// the default multiply latency and a per-stage control bundle.
package constants_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MUL_WAIT = 1'b1
    } pipe_ctrl_state_t;

    localparam int MUL_LATENCY_DEFAULT = 4;
    localparam int MUL_CNT_W           = 4;

    typedef struct packed {
        logic en;
        logic bubble;
    } stage_ctrl_t;

endpackage

// File: rtl/perf_counter.sv
// Free-running wrapping event counter with synchronous reset and an
// increment enable.
module perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [CNT_W-1:0] ONE = 1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i) begin
            count_d = count_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage core: one prioritised decision per
// cycle drives the load-enable and bubble of every pipeline register.
module pipeline_ctrl
    import constants_pkg::*;
#(
    parameter int MUL_LATENCY = MUL_LATENCY_DEFAULT,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_dec_in,
    input  logic             mem_busy_in,
    input  logic             mul_issue_in,
    input  logic             br_taken_in,
    output logic             pc_en_out,
    output logic             pc_redirect_out,
    output logic             fd_en_out,
    output logic             fd_flush_out,
    output logic             de_en_out,
    output logic             de_bubble_out,
    output logic             em_en_out,
    output logic             em_bubble_out,
    output logic             mw_en_out,
    output logic             mw_bubble_out,
    output logic [CNT_W-1:0] stall_cycles_out,
    output logic [CNT_W-1:0] flush_count_out
);

    // The issue cycle is the first stall cycle, so the countdown covers the rest.
    localparam logic                 MUL_STALLS = (MUL_LATENCY > 1);
    localparam logic [MUL_CNT_W-1:0] MUL_RELOAD =
        (MUL_LATENCY > 1) ? MUL_CNT_W'(MUL_LATENCY - 2) : MUL_CNT_W'(0);

    pipe_ctrl_state_t     state_q;
    pipe_ctrl_state_t     state_d;
    logic [MUL_CNT_W-1:0] mul_cnt_q;
    logic [MUL_CNT_W-1:0] mul_cnt_d;

    stage_ctrl_t fd_c;
    stage_ctrl_t de_c;
    stage_ctrl_t em_c;
    stage_ctrl_t mw_c;
    logic        pc_en;
    logic        pc_redirect;
    logic        mul_stall;
    logic        stall_inc;
    logic        flush_inc;

    assign mul_stall = ((state_q == MUL_WAIT) && (mul_cnt_q != '0)) ||
                       ((state_q == RUN) && mul_issue_in && MUL_STALLS);

    always_comb begin
        state_d     = state_q;
        mul_cnt_d   = mul_cnt_q;
        pc_en       = 1'b1;
        pc_redirect = 1'b0;
        fd_c        = '{en: 1'b1, bubble: 1'b0};
        de_c        = '{en: 1'b1, bubble: 1'b0};
        em_c        = '{en: 1'b1, bubble: 1'b0};
        mw_c        = '{en: 1'b1, bubble: 1'b0};
        flush_inc   = 1'b0;

        if (rst) begin
            pc_en = 1'b0;
            fd_c  = '{en: 1'b0, bubble: 1'b0};
            de_c  = '{en: 1'b0, bubble: 1'b0};
            em_c  = '{en: 1'b0, bubble: 1'b0};
            mw_c  = '{en: 1'b0, bubble: 1'b0};
        end else if (mem_busy_in) begin
            // Whole pipe freezes behind MEM; the multiply countdown pauses too.
            pc_en       = 1'b0;
            fd_c.en     = 1'b0;
            de_c.en     = 1'b0;
            em_c.en     = 1'b0;
            mw_c.bubble = 1'b1;
        end else if (mul_stall) begin
            pc_en       = 1'b0;
            fd_c.en     = 1'b0;
            de_c.en     = 1'b0;
            em_c.bubble = 1'b1;
            if (state_q == RUN) begin
                state_d   = MUL_WAIT;
                mul_cnt_d = MUL_RELOAD;
            end else begin
                mul_cnt_d = mul_cnt_q - 1'b1;
            end
        end else begin
            // Release cycle of a multiply falls through to the ordinary rules.
            state_d = RUN;
            if (br_taken_in) begin
                pc_redirect  = 1'b1;
                fd_c.bubble  = 1'b1;
                de_c.bubble  = 1'b1;
                flush_inc    = 1'b1;
            end else if (stall_dec_in) begin
                pc_en       = 1'b0;
                fd_c.en     = 1'b0;
                de_c.bubble = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            mul_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            mul_cnt_q <= mul_cnt_d;
        end
    end

    assign stall_inc = !rst && !pc_en;

    perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (stall_inc),
        .count_o (stall_cycles_out)
    );

    perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (flush_inc),
        .count_o (flush_count_out)
    );

    assign pc_en_out       = pc_en;
    assign pc_redirect_out = pc_redirect;
    assign fd_en_out       = fd_c.en;
    assign fd_flush_out    = fd_c.bubble;
    assign de_en_out       = de_c.en;
    assign de_bubble_out   = de_c.bubble;
    assign em_en_out       = em_c.en;
    assign em_bubble_out   = em_c.bubble;
    assign mw_en_out       = mw_c.en;
    assign mw_bubble_out   = mw_c.bubble;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: two instances (latency 4 / 4-bit
// counters, latency 1 / 8-bit counters) checked against a cycle model.
module tb_pipeline_ctrl;

    localparam int LAT_A = 4;
    localparam int CW_A  = 4;
    localparam int LAT_B = 1;
    localparam int CW_B  = 8;

    logic clk = 1'b0;
    logic rst, stall_dec, mem_busy, mul_issue, br_taken;
    always #5 clk = ~clk;

    logic a_pe, a_pr, a_fe, a_ff, a_de, a_db, a_ee, a_eb, a_me, a_mb;
    logic b_pe, b_pr, b_fe, b_ff, b_de, b_db, b_ee, b_eb, b_me, b_mb;
    logic [CW_A-1:0] a_sc, a_fc;
    logic [CW_B-1:0] b_sc, b_fc;

    pipeline_ctrl #(.MUL_LATENCY(LAT_A), .CNT_W(CW_A)) dut_a (
        .clk(clk), .rst(rst), .stall_dec_in(stall_dec), .mem_busy_in(mem_busy),
        .mul_issue_in(mul_issue), .br_taken_in(br_taken),
        .pc_en_out(a_pe), .pc_redirect_out(a_pr), .fd_en_out(a_fe), .fd_flush_out(a_ff),
        .de_en_out(a_de), .de_bubble_out(a_db), .em_en_out(a_ee), .em_bubble_out(a_eb),
        .mw_en_out(a_me), .mw_bubble_out(a_mb),
        .stall_cycles_out(a_sc), .flush_count_out(a_fc)
    );

    pipeline_ctrl #(.MUL_LATENCY(LAT_B), .CNT_W(CW_B)) dut_b (
        .clk(clk), .rst(rst), .stall_dec_in(stall_dec), .mem_busy_in(mem_busy),
        .mul_issue_in(mul_issue), .br_taken_in(br_taken),
        .pc_en_out(b_pe), .pc_redirect_out(b_pr), .fd_en_out(b_fe), .fd_flush_out(b_ff),
        .de_en_out(b_de), .de_bubble_out(b_db), .em_en_out(b_ee), .em_bubble_out(b_eb),
        .mw_en_out(b_me), .mw_bubble_out(b_mb),
        .stall_cycles_out(b_sc), .flush_count_out(b_fc)
    );

    // Per-register action: 0 = hold, 1 = load, 2 = bubble (PC: branch target).
    typedef struct packed {
        logic [9:0] act_a;
        logic [9:0] act_b;
        logic [7:0] sc_a;
        logic [7:0] fc_a;
        logic [7:0] sc_b;
        logic [7:0] fc_b;
        logic       cnt_ok;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   cnt_known = 0;

    int age_a = 0, sc_a = 0, fc_a = 0;
    int age_b = 0, sc_b = 0, fc_b = 0;

    function automatic logic [9:0] act_of(input logic pe, pr, fe, ff, de, db,
                                          ee, eb, me, mb);
        logic [1:0] p, f, d, e, m;
        p = pe ? (pr ? 2'd2 : 2'd1) : 2'd0;
        f = ff ? 2'd2 : (fe ? 2'd1 : 2'd0);
        d = db ? 2'd2 : (de ? 2'd1 : 2'd0);
        e = eb ? 2'd2 : (ee ? 2'd1 : 2'd0);
        m = mb ? 2'd2 : (me ? 2'd1 : 2'd0);
        return {p, f, d, e, m};
    endfunction

    // age counts completed EXE-occupancy cycles of the multiply in flight (0 = none).
    task automatic model(input int lat, input int cw, inout int age, inout int sc,
                         inout int fc, output logic [9:0] act,
                         output logic [7:0] sc_o, output logic [7:0] fc_o);
        int pc, fd, de, em, mw;
        bit ms;
        sc_o = 8'(sc);
        fc_o = 8'(fc);
        pc = 1; fd = 1; de = 1; em = 1; mw = 1;
        if (rst) begin
            pc = 0; fd = 0; de = 0; em = 0; mw = 0;
            age = 0; sc = 0; fc = 0;
        end else if (mem_busy) begin
            pc = 0; fd = 0; de = 0; em = 0; mw = 2;
            sc++;
        end else begin
            ms = (age > 0 && age < lat - 1) || (age == 0 && mul_issue && lat > 1);
            if (ms) begin
                pc = 0; fd = 0; de = 0; em = 2; mw = 1;
                sc++;
                age++;
            end else begin
                age = 0;
                if (br_taken) begin
                    pc = 2; fd = 2; de = 2;
                    fc++;
                end else if (stall_dec) begin
                    pc = 0; fd = 0; de = 2;
                    sc++;
                end
            end
        end
        sc = sc % (1 << cw);
        fc = fc % (1 << cw);
        act = {2'(pc), 2'(fd), 2'(de), 2'(em), 2'(mw)};
    endtask

    task automatic step(input bit r, input bit s, input bit b, input bit m, input bit br);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; stall_dec = s; mem_busy = b; mul_issue = m; br_taken = br;
        e.cnt_ok = cnt_known;
        model(LAT_A, CW_A, age_a, sc_a, fc_a, e.act_a, e.sc_a, e.fc_a);
        model(LAT_B, CW_B, age_b, sc_b, fc_b, e.act_b, e.sc_b, e.fc_b);
        if (r) cnt_known = 1;
        sb.push_back(e);
    endtask

    task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("ctl_a", act_of(a_pe, a_pr, a_fe, a_ff, a_de, a_db, a_ee, a_eb, a_me, a_mb), e.act_a);
            check("ctl_b", act_of(b_pe, b_pr, b_fe, b_ff, b_de, b_db, b_ee, b_eb, b_me, b_mb), e.act_b);
            if (e.cnt_ok) begin
                check("stall_cnt_a", 10'(a_sc), 10'(e.sc_a));
                check("flush_cnt_a", 10'(a_fc), 10'(e.fc_a));
                check("stall_cnt_b", 10'(b_sc), 10'(e.sc_b));
                check("flush_cnt_b", 10'(b_fc), 10'(e.fc_b));
            end
        end
    end

    initial begin
        rst = 1'b1; stall_dec = 1'b0; mem_busy = 1'b0; mul_issue = 1'b1; br_taken = 1'b0;
        repeat (3) step(1, 0, 0, 1, 0);
        repeat (2) step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 1);                    // branch overrides decode stall
        repeat (2) step(0, 1, 0, 0, 0);         // decode stall
        repeat (2) step(0, 0, 0, 0, 0);
        repeat (4) step(0, 0, 0, 1, 0);         // multiply, held through release
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);                    // multiply with mem_busy inside
        repeat (2) step(0, 0, 1, 1, 0);
        repeat (3) step(0, 0, 0, 1, 0);
        repeat (2) step(0, 0, 0, 0, 0);
        repeat (2) step(0, 0, 1, 0, 1);         // branch frozen behind MEM
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 0);                    // reset aborts a multiply
        step(1, 0, 0, 1, 0);
        repeat (17) step(0, 1, 0, 0, 0);        // 4-bit counter wraps
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 5) == 0);
        end
        step(0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
